load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sequencing stage directly upstream of instruction_data_memory.
- Accepts one load/store request at a time from the core's execute stage over a valid/ready handshake.
- Checks alignment, range and funct3, then drives the memory's size strobes, address and write data for exactly one cycle.
- Returns sign- or zero-extended load data over a valid/ready response handshake; faulting requests never touch memory.

Parameters:
- num_thirty_two_bit_words, 128: memory depth in 32-bit words; must match the memory instance.
- ADDR_W, $clog2(num_thirty_two_bit_words*4): byte-address width toward memory (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_write  input  1  1=store, 0=load
- req_funct3  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_address  input  32  byte address
- req_store_data  input  32  store data, right-aligned
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_load_data  output  32  extended load result; 0 for stores and faults
- resp_fault  output  1  request rejected: misaligned, out of range or illegal funct3
- mem_write_enable  output  1  to memory write_enable
- mem_word  output  1  to memory word strobe
- mem_half  output  1  to memory half strobe
- mem_single_byte  output  1  to memory single_byte strobe
- mem_address  output  ADDR_W  to memory address
- mem_write_data  output  32  to memory write_data
- mem_read_data  input  32  from memory read_data (combinational, zero-extended by memory)

Behaviour:
- Reset: state=IDLE; resp_valid=0, resp_fault=0, resp_load_data=0; all internal request registers cleared.
- Memory-side outputs during reset: mem_* strobes and mem_write_enable forced 0 combinationally while reset=1.
- State IDLE:
  - req_ready=1.
  - On req_valid: register write/funct3/address/store_data.
  - If the fault check fails, go to RESP with fault=1.
  - Otherwise go to ACCESS.
- State ACCESS (exactly one cycle):
  - Exactly one of mem_word/mem_half/mem_single_byte is 1, decoded from funct3[1:0].
  - mem_address = registered address[ADDR_W-1:0]; mem_write_data = registered store_data.
  - mem_write_enable = registered write.
  - On the clock edge, capture mem_read_data into resp_load_data:
    - LB: sign-extend bit 7.
    - LH: sign-extend bit 15.
    - LW: take as is.
    - LBU/LHU: take as is.
    - Store: capture 0.
  - Then go to RESP.
- State RESP:
  - resp_valid=1; resp_load_data and resp_fault held stable until resp_valid && resp_ready.
  - On that handshake, go to IDLE.
  - req_ready=0, so no back-to-back overlap.
- Outside ACCESS: mem_write_enable, mem_word, mem_half and mem_single_byte are all 0. mem_address and mem_write_data are 0.
- Latency, with resp_ready held 1: accept at edge N, ACCESS in cycle N+1, resp_valid in cycle N+2. Throughput is one request per 3 cycles.
- Fault check (any true sets fault):
  - Halfword with address[0]=1.
  - Word with address[1:0]!=0.
  - address >= num_thirty_two_bit_words*4, i.e. any bit above ADDR_W-1 set.
  - Load funct3 in {011,110,111}.
  - Store funct3 not in {000,001,010}.
- Faulting requests skip ACCESS: no memory strobe is asserted and no write occurs. resp_load_data=0.
- Reset asserted in any state: next state IDLE, pending response discarded, and no write in that cycle.
- req_valid while not in IDLE is ignored and must be held by the requester.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF -> ACCESS cycle shows mem_write_enable=1, mem_word=1, mem_address=0x10. Response: fault=0, load_data=0, resp_valid two cycles after accept.
- After that store: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD; LW 0x10 -> 0xDEADBEEF.
- SH 0x21, LW 0x22 and LW 0x200 (num_thirty_two_bit_words=128) -> each gives resp_fault=1 and load_data=0. mem_write_enable stays 0 throughout and the memory at 0x20 is unchanged.
- Illegal funct3: load 011 and store 100 -> resp_fault=1 with no memory strobes.
- Backpressure: hold resp_ready=0 for 5 cycles after an LW -> resp_valid and data stay stable, req_ready=0, and a second req_valid is not accepted until after the handshake.
- Reset asserted during the ACCESS cycle of SW 0x30 data 0x12345678 -> mem_write_enable=0. A subsequent LW 0x30 returns the prior contents, and the unit is in IDLE with resp_valid=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of instruction_data_memory: validates one request,
// drives the memory for a single ACCESS cycle, then returns an extended result.
module load_store_unit #(
    parameter  int num_thirty_two_bit_words = 128,
    localparam int ADDR_W = $clog2(num_thirty_two_bit_words * 4)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_address,
    input  logic [31:0]       req_store_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_load_data,
    output logic              resp_fault,
    output logic              mem_write_enable,
    output logic              mem_word,
    output logic              mem_half,
    output logic              mem_single_byte,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_write;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_address;
    logic [31:0]       r_storeData;
    logic [31:0]       r_loadData;
    logic              r_fault;

    logic              w_misaligned;
    logic              w_outOfRange;
    logic              w_badFunct3;
    logic              w_fault;
    logic [31:0]       w_extended;

    // Request validation is done on the raw inputs so a bad request can skip ACCESS.
    always_comb begin
        w_misaligned = ((req_funct3[1:0] == 2'b01) && req_address[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
        w_outOfRange = |req_address[31:ADDR_W];
        if (req_write) begin
            w_badFunct3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            w_badFunct3 = req_funct3 inside {3'b011, 3'b110, 3'b111};
        end
        w_fault = w_misaligned || w_outOfRange || w_badFunct3;
    end

    always_comb begin
        w_extended = mem_read_data;
        if (r_write) begin
            w_extended = '0;
        end else if (r_funct3 == 3'b000) begin
            w_extended = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
        end else if (r_funct3 == 3'b001) begin
            w_extended = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Memory-side outputs are gated by reset as well, so a reset landing on ACCESS never writes.
    always_comb begin
        w_nextState      = r_state;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_write_enable = 1'b0;
        mem_word         = 1'b0;
        mem_half         = 1'b0;
        mem_single_byte  = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_nextState = w_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                w_nextState = RESP;
                if (!reset) begin
                    mem_write_enable = r_write;
                    mem_address      = r_address;
                    mem_write_data   = r_storeData;
                    case (r_funct3[1:0])
                        2'b00:   mem_single_byte = 1'b1;
                        2'b01:   mem_half        = 1'b1;
                        default: mem_word        = 1'b1;
                    endcase
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write     <= 1'b0;
            r_funct3    <= '0;
            r_address   <= '0;
            r_storeData <= '0;
            r_loadData  <= '0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_funct3    <= req_funct3;
                        r_address   <= req_address[ADDR_W-1:0];
                        r_storeData <= req_store_data;
                        r_loadData  <= '0;
                        r_fault     <= w_fault;
                    end
                end
                ACCESS: begin
                    r_loadData <= w_extended;
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_load_data = r_loadData;
    assign resp_fault     = r_fault;

endmodule
